// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types and proc line-memory constants.
// Imported by the interface, the grant unit and the top.
package mem_arbiter_pkg;

  localparam int PROC_ARCH_BITS        = 32;
  localparam int PROC_MEMORY_LINE_BITS = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the caches, the arbiter and memory.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ARCH_BITS = PROC_ARCH_BITS,
  parameter int LINE_BITS = PROC_MEMORY_LINE_BITS
) ();

  logic                 ic_req_valid;
  logic [ARCH_BITS-1:0] ic_req_addr;
  logic                 ic_req_ready;
  logic                 ic_rsp_valid;
  logic [LINE_BITS-1:0] ic_rsp_data;

  logic                 dc_req_valid;
  logic                 dc_req_we;
  logic [ARCH_BITS-1:0] dc_req_addr;
  logic [LINE_BITS-1:0] dc_req_wdata;
  logic                 dc_req_ready;
  logic                 dc_rsp_valid;
  logic [LINE_BITS-1:0] dc_rsp_data;

  logic [ARCH_BITS-1:0] mem_raddr;
  logic [ARCH_BITS-1:0] mem_waddr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic                 mem_we;
  logic [LINE_BITS-1:0] mem_rdata;
  logic                 mem_rvalid;
  logic                 mem_wdone;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_rsp_valid, ic_rsp_data,
    input  dc_req_valid, dc_req_we, dc_req_addr,
    input  dc_req_wdata,
    output dc_req_ready, dc_rsp_valid, dc_rsp_data,
    output mem_raddr, mem_waddr, mem_wdata, mem_we,
    input  mem_rdata, mem_rvalid, mem_wdone
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_rsp_valid, ic_rsp_data,
    output dc_req_valid, dc_req_we, dc_req_addr,
    output dc_req_wdata,
    input  dc_req_ready, dc_rsp_valid, dc_rsp_data,
    input  mem_raddr, mem_waddr, mem_wdata, mem_we,
    output mem_rdata, mem_rvalid, mem_wdone
  );

endinterface

// File: rtl/mem_arbiter_grant.sv
// mem_arb_grant: picks icache or dcache while the arbiter is idle.
// MEM_ARB_ROUND_ROBIN_EN alternates on ties; otherwise dcache wins.
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_ic_valid,
  input  logic i_dc_valid,
  output logic o_ic_ready,
  output logic o_dc_ready
);

  logic w_dc_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  mem_arb_owner_t r_last;

  assign w_dc_win = i_dc_valid &
                    (~i_ic_valid | (r_last == OWN_IC));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= OWN_IC;
    end else if (o_dc_ready) begin
      r_last <= OWN_DC;
    end else if (o_ic_ready) begin
      r_last <= OWN_IC;
    end
  end
`else
  logic w_unused;

  assign w_dc_win = i_dc_valid;
  assign w_unused = clk ^ rst;
`endif

  assign o_dc_ready = i_idle & w_dc_win;
  assign o_ic_ready = i_idle & i_ic_valid & ~w_dc_win;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-at-a-time line memory sharing for icache/dcache.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin grant on ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ARCH_BITS = PROC_ARCH_BITS,
  parameter int LINE_BITS = PROC_MEMORY_LINE_BITS
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  mem_arb_state_t       r_state;
  mem_arb_state_t       w_next;
  mem_arb_owner_t       r_owner;
  logic [ARCH_BITS-1:0] r_addr;
  logic [LINE_BITS-1:0] r_wdata;
  logic [LINE_BITS-1:0] r_ic_data;
  logic [LINE_BITS-1:0] r_dc_data;
  logic                 r_ic_vld;
  logic                 r_dc_vld;
  logic                 w_idle;
  logic                 w_ic_rdy;
  logic                 w_dc_rdy;
  logic                 w_rd_done;
  logic                 w_wr_done;

  assign w_idle    = (r_state == IDLE);
  assign w_rd_done = (r_state == READ) & bus.mem_rvalid;
  assign w_wr_done = (r_state == WRITE) & bus.mem_wdone;

  mem_arb_grant u_grant (
    .clk        (clk),
    .rst        (rst),
    .i_idle     (w_idle),
    .i_ic_valid (bus.ic_req_valid),
    .i_dc_valid (bus.dc_req_valid),
    .o_ic_ready (w_ic_rdy),
    .o_dc_ready (w_dc_rdy)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_dc_rdy) begin
          w_next = bus.dc_req_we ? WRITE : READ;
        end else if (w_ic_rdy) begin
          w_next = READ;
        end
      end
      READ:    if (w_rd_done) w_next = GAP;
      WRITE:   if (w_wr_done) w_next = GAP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Response pulses land in GAP, one cycle after rvalid/wdone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_owner   <= OWN_IC;
      r_ic_data <= '0;
      r_dc_data <= '0;
      r_ic_vld  <= 1'b0;
      r_dc_vld  <= 1'b0;
    end else begin
      r_ic_vld <= 1'b0;
      r_dc_vld <= 1'b0;
      if (w_dc_rdy) begin
        r_addr  <= bus.dc_req_addr;
        r_wdata <= bus.dc_req_wdata;
        r_owner <= OWN_DC;
      end else if (w_ic_rdy) begin
        r_addr  <= bus.ic_req_addr;
        r_owner <= OWN_IC;
      end
      if (w_rd_done) begin
        if (r_owner == OWN_DC) begin
          r_dc_data <= bus.mem_rdata;
          r_dc_vld  <= 1'b1;
        end else begin
          r_ic_data <= bus.mem_rdata;
          r_ic_vld  <= 1'b1;
        end
      end
      if (w_wr_done) begin
        r_dc_data <= '0;
        r_dc_vld  <= 1'b1;
      end
    end
  end

  // Parking on ~addr forces the memory to restart its delay count.
  assign bus.mem_raddr = (r_state == READ)  ? r_addr : ~r_addr;
  assign bus.mem_waddr = (r_state == WRITE) ? r_addr : ~r_addr;
  assign bus.mem_we    = (r_state == WRITE);
  assign bus.mem_wdata = r_wdata;

  assign bus.ic_req_ready = w_ic_rdy;
  assign bus.ic_rsp_valid = r_ic_vld;
  assign bus.ic_rsp_data  = r_ic_data;
  assign bus.dc_req_ready = w_dc_rdy;
  assign bus.dc_rsp_valid = r_dc_vld;
  assign bus.dc_rsp_data  = r_dc_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a line memory and a reference model.
// Build with MEM_ARB_ROUND_ROBIN_EN to exercise round-robin ties.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int LAT = 5;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ARCH_BITS(AW), .LINE_BITS(LW)) bus ();

  mem_arbiter #(.ARCH_BITS(AW), .LINE_BITS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input int i);
    logic [7:0] b;
    b = 8'hA1 ^ 8'(i);
    return {16{b}};
  endfunction

  // Line memory: delay restarts whenever the address (or we) changes.
  logic [LW-1:0] mem_arr [64];
  logic [AW-1:0] m_last_ra = '0;
  logic [AW:0]   m_last_wk = '0;
  int            m_rcnt = 0;
  int            m_wcnt = 0;
  int            m_rnow;
  int            m_wnow;

  always_comb begin
    m_rnow = 1;
    m_wnow = 1;
    if (bus.mem_raddr == m_last_ra)
      m_rnow = (m_rcnt < 1000) ? m_rcnt + 1 : m_rcnt;
    if ({bus.mem_we, bus.mem_waddr} == m_last_wk)
      m_wnow = (m_wcnt < 1000) ? m_wcnt + 1 : m_wcnt;
  end

  assign bus.mem_rvalid = (m_rnow >= LAT);
  assign bus.mem_wdone  = bus.mem_we && (m_wnow >= LAT);
  assign bus.mem_rdata  = mem_arr[bus.mem_raddr[9:4]];

  always @(posedge clk) begin
    m_rcnt    <= m_rnow;
    m_wcnt    <= m_wnow;
    m_last_ra <= bus.mem_raddr;
    m_last_wk <= {bus.mem_we, bus.mem_waddr};
    if (bus.mem_wdone)
      mem_arr[bus.mem_waddr[9:4]] <= bus.mem_wdata;
  end

  // Reference model: contents, expected responses, occupancy, grant.
  typedef struct {
    int            due;
    logic [LW-1:0] data;
  } rsp_t;

  logic [LW-1:0] ref_mem [64];
  rsp_t          ic_q[$];
  rsp_t          dc_q[$];
  int            cyc        = 0;
  int            busy_until = -1;
  int            acc_cyc    = -100;
  logic          acc_we     = 1'b0;
  logic [AW-1:0] acc_addr   = '0;
  logic [LW-1:0] acc_wdata  = '0;
  logic          last_dc    = 1'b0;
  logic [LW-1:0] ic_last    = '0;
  logic [LW-1:0] dc_last    = '0;
  int            ic_acc_at  = 0;
  int            dc_acc_at  = 0;

  logic          t_idle, t_dc_win, t_rd_on, t_wr_on;
  logic          t_ic_due, t_dc_due;
  logic [AW-1:0] t_ra, t_wa;
  rsp_t          t_r;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      ic_q.delete();
      dc_q.delete();
      busy_until = cyc;
      acc_cyc    = -100;
      acc_we     = 1'b0;
      acc_addr   = '0;
      acc_wdata  = '0;
      last_dc    = 1'b0;
      ic_last    = '0;
      dc_last    = '0;
    end else begin
      t_idle = (cyc > busy_until);
      if (RR)
        t_dc_win = bus.dc_req_valid &&
                   (!bus.ic_req_valid || !last_dc);
      else
        t_dc_win = bus.dc_req_valid;
      check("dc_ready", bus.dc_req_ready, t_idle && t_dc_win);
      check("ic_ready", bus.ic_req_ready,
            t_idle && bus.ic_req_valid && !t_dc_win);

      t_rd_on = !acc_we && cyc > acc_cyc && cyc <= acc_cyc + LAT;
      t_wr_on = acc_we && cyc > acc_cyc && cyc <= acc_cyc + LAT;
      t_ra = t_rd_on ? acc_addr : ~acc_addr;
      t_wa = t_wr_on ? acc_addr : ~acc_addr;
      check("mem_raddr", bus.mem_raddr, t_ra);
      check("mem_waddr", bus.mem_waddr, t_wa);
      check("mem_we", bus.mem_we, t_wr_on);
      if (t_wr_on) check("mem_wdata", bus.mem_wdata, acc_wdata);

      t_ic_due = ic_q.size() > 0 && ic_q[0].due == cyc;
      t_dc_due = dc_q.size() > 0 && dc_q[0].due == cyc;
      check("ic_rsp_valid", bus.ic_rsp_valid, t_ic_due);
      check("dc_rsp_valid", bus.dc_rsp_valid, t_dc_due);
      if (t_ic_due) begin
        t_r = ic_q.pop_front();
        ic_last = t_r.data;
      end
      if (t_dc_due) begin
        t_r = dc_q.pop_front();
        dc_last = t_r.data;
      end
      check("ic_rsp_data", bus.ic_rsp_data, ic_last);
      check("dc_rsp_data", bus.dc_rsp_data, dc_last);

      if (bus.dc_req_valid && bus.dc_req_ready) begin
        acc_cyc    = cyc;
        acc_we     = bus.dc_req_we;
        acc_addr   = bus.dc_req_addr;
        acc_wdata  = bus.dc_req_wdata;
        busy_until = cyc + LAT + 1;
        dc_acc_at  = cyc;
        last_dc    = 1'b1;
        t_r.due    = cyc + LAT + 1;
        if (bus.dc_req_we) begin
          ref_mem[bus.dc_req_addr[9:4]] = bus.dc_req_wdata;
          t_r.data = '0;
        end else begin
          t_r.data = ref_mem[bus.dc_req_addr[9:4]];
        end
        dc_q.push_back(t_r);
      end else if (bus.ic_req_valid && bus.ic_req_ready) begin
        acc_cyc    = cyc;
        acc_we     = 1'b0;
        acc_addr   = bus.ic_req_addr;
        busy_until = cyc + LAT + 1;
        ic_acc_at  = cyc;
        last_dc    = 1'b0;
        t_r.due    = cyc + LAT + 1;
        t_r.data   = ref_mem[bus.ic_req_addr[9:4]];
        ic_q.push_back(t_r);
      end
    end
  end

  task automatic ic_req(input logic [AW-1:0] a);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = a;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.ic_req_ready;
    end
    check("ic_accept", ok, 1'b1);
    @(posedge clk); #1;
    bus.ic_req_valid = 1'b0;
  endtask

  task automatic dc_req(input logic we,
                        input logic [AW-1:0] a,
                        input logic [LW-1:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_we    = we;
    bus.dc_req_addr  = a;
    bus.dc_req_wdata = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.dc_req_ready;
    end
    check("dc_accept", ok, 1'b1);
    @(posedge clk); #1;
    bus.dc_req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = (cyc > busy_until) && ic_q.size() == 0 &&
           dc_q.size() == 0;
    end
    check("drain", ok, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] pat;
    pat = {8{16'h1234}};
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = init_line(i);
      ref_mem[i] = init_line(i);
    end
    bus.ic_req_valid = 1'b0;
    bus.ic_req_addr  = '0;
    bus.dc_req_valid = 1'b0;
    bus.dc_req_we    = 1'b0;
    bus.dc_req_addr  = '0;
    bus.dc_req_wdata = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_raddr", bus.mem_raddr, 32'hFFFF_FFFF);
    check("rst_waddr", bus.mem_waddr, 32'hFFFF_FFFF);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_ic_vld", bus.ic_rsp_valid, 1'b0);
    check("rst_dc_data", bus.dc_rsp_data, '0);

    ic_req(32'h40);
    drain();
    check("ic40_data", bus.ic_rsp_data, {16{8'hA5}});

    fork
      ic_req(32'h10);
      dc_req(1'b0, 32'h20, '0);
    join
    drain();
    check("pair1_dc_first", dc_acc_at < ic_acc_at, 1'b1);

    dc_req(1'b0, 32'h20, '0);
    drain();
    fork
      ic_req(32'h10);
      dc_req(1'b0, 32'h20, '0);
    join
    drain();
    check("pair2_order", dc_acc_at < ic_acc_at, !RR);

    dc_req(1'b1, 32'h30, pat);
    dc_req(1'b0, 32'h30, '0);
    drain();
    check("dc30_readback", bus.dc_rsp_data, pat);

    ic_req(32'h50);
    ic_req(32'h50);
    drain();

    ic_req(32'h60);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_we", bus.mem_we, 1'b0);
    check("rst_mid_raddr", bus.mem_raddr, 32'hFFFF_FFFF);
    ic_req(32'h60);
    drain();
    check("ic60_reissue", bus.ic_rsp_data, {16{8'hA7}});

    fork
      dc_req(1'b1, 32'h70, ~pat);
      begin
        repeat (2) @(posedge clk);
        ic_req(32'h80);
      end
    join
    drain();

    fork
      for (int i = 0; i < 25; i++) begin
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 63)) << 4;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        ic_req(a);
      end
      for (int j = 0; j < 25; j++) begin
        logic [AW-1:0] b;
        b = AW'($urandom_range(0, 63)) << 4;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        dc_req(1'($urandom_range(0, 1)), b,
               {$urandom, $urandom, $urandom, $urandom});
      end
    join
    drain();
    check("ic_q_left", 32'(ic_q.size()), '0);
    check("dc_q_left", 32'(dc_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
